// File: rtl/clock_enable_gen_if.sv
// Control and status bundle for clock_enable_gen: divisor load, run level and the
// generated clock / enable / status outputs.
interface clock_enable_gen_if #(
    parameter int DIV_WIDTH = 32
);
    logic [DIV_WIDTH-1:0] div_value;
    logic                 div_load;
    logic                 run;
    logic                 div_busy;
    logic                 clk_out;
    logic                 clk_en;
    logic                 active;
    logic [DIV_WIDTH-1:0] edge_count;

    modport master (
        output div_value, div_load, run,
        input  div_busy, clk_out, clk_en, active, edge_count
    );

    modport slave (
        input  div_value, div_load, run,
        output div_busy, clk_out, clk_en, active, edge_count
    );
endinterface

// File: rtl/clock_enable_gen.sv
// Programmable square-wave generator: clk_out is high D cycles and low D cycles,
// with a new divisor taking effect only at a period boundary or while idle.
//
// state  | meaning
// IDLE   | stopped, clk_out low, waiting for run with a nonzero divisor
// HIGH   | high phase of clk_out, first cycle carries clk_en
// LOW    | low phase; its last cycle is the period boundary
module clock_enable_gen #(
    parameter int DIV_WIDTH = 32
) (
    input  logic               s_axi_aclk,
    input  logic               aresetn,
    clock_enable_gen_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [DIV_WIDTH-1:0] r_d;
    logic [DIV_WIDTH-1:0] r_p;
    logic [DIV_WIDTH-1:0] r_cnt;
    logic [DIV_WIDTH-1:0] r_edge_count;
    logic [DIV_WIDTH-1:0] w_cnt_nxt;
    logic [DIV_WIDTH-1:0] w_d_eff;
    logic                 r_busy;
    logic                 r_clk_out;
    logic                 r_clk_en;
    logic                 r_active;
    logic                 w_last;
    logic                 w_xfer;
    logic                 w_enter_high;

    // The pending divisor is visible to the IDLE/boundary decision on the same
    // edge it is applied, so the following period already uses it.
    always_comb begin
        w_last       = (r_cnt == (r_d - DIV_WIDTH'(1)));
        w_xfer       = r_busy && ((r_state == S_IDLE) || ((r_state == S_LOW) && w_last));
        w_d_eff      = w_xfer ? r_p : r_d;
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (bus.run && (w_d_eff != '0)) begin
                    w_state_nxt = S_HIGH;
                end
            end
            S_HIGH: begin
                if (w_last) begin
                    w_state_nxt = S_LOW;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + DIV_WIDTH'(1);
                end
            end
            S_LOW: begin
                if (w_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = (bus.run && (w_d_eff != '0)) ? S_HIGH : S_IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt + DIV_WIDTH'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        w_enter_high = (w_state_nxt == S_HIGH) && (r_state != S_HIGH);
    end

    always_ff @(posedge s_axi_aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_d          <= '0;
            r_p          <= '0;
            r_busy       <= 1'b0;
            r_clk_out    <= 1'b0;
            r_clk_en     <= 1'b0;
            r_active     <= 1'b0;
            r_edge_count <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_clk_out <= (w_state_nxt == S_HIGH);
            r_clk_en  <= w_enter_high;
            r_active  <= (w_state_nxt != S_IDLE);
            if (w_enter_high) begin
                r_edge_count <= r_edge_count + DIV_WIDTH'(1);
            end
            if (w_xfer) begin
                r_d <= r_p;
            end
            // A load coinciding with a transfer keeps busy set for the new value.
            if (bus.div_load) begin
                r_p    <= bus.div_value;
                r_busy <= 1'b1;
            end else if (w_xfer) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign bus.div_busy   = r_busy;
    assign bus.clk_out    = r_clk_out;
    assign bus.clk_en     = r_clk_en;
    assign bus.active     = r_active;
    assign bus.edge_count = r_edge_count;
endmodule

// File: tb/tb_clock_enable_gen.sv
// Directed bench for clock_enable_gen: a 32-bit instance for sequencing and divisor
// updates, and a 4-bit instance for edge_count wrap.
module tb_clock_enable_gen;
    logic s_axi_aclk = 1'b0;
    logic aresetn    = 1'b0;
    int   n_checks   = 0;
    int   n_fail     = 0;

    clock_enable_gen_if #(.DIV_WIDTH(32)) bus_a ();
    clock_enable_gen_if #(.DIV_WIDTH(4))  bus_b ();

    clock_enable_gen #(.DIV_WIDTH(32)) u_dut_a (
        .s_axi_aclk (s_axi_aclk),
        .aresetn    (aresetn),
        .bus        (bus_a.slave)
    );

    clock_enable_gen #(.DIV_WIDTH(4)) u_dut_b (
        .s_axi_aclk (s_axi_aclk),
        .aresetn    (aresetn),
        .bus        (bus_b.slave)
    );

    always #5 s_axi_aclk = ~s_axi_aclk;

    // Expected values for the D=3 -> D=1 -> D=4 -> stop sequence, index 0 leftmost.
    logic [0:20] seq_ld   = 21'b001000000010000000000;
    logic [0:20] seq_run  = 21'b111111111111110000000;
    logic [0:20] exp_out  = 21'b111000101010111100000;
    logic [0:20] exp_en   = 21'b100000101010100000000;
    logic [0:20] exp_busy = 21'b001111000011000000000;
    logic [0:20] exp_act  = 21'b111111111111111111110;
    int          exp_cnt [21] = '{4,4,4,4,4,4,5,5,6,6,7,7,8,8,8,8,8,8,8,8,8};

    task automatic tick();
        @(posedge s_axi_aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a_zero(input string tag);
        chk({tag, ".clk_out"},  32'(bus_a.clk_out),  32'd0);
        chk({tag, ".clk_en"},   32'(bus_a.clk_en),   32'd0);
        chk({tag, ".active"},   32'(bus_a.active),   32'd0);
        chk({tag, ".busy"},     32'(bus_a.div_busy), 32'd0);
        chk({tag, ".edge_cnt"}, bus_a.edge_count,    32'd0);
    endtask

    initial begin
        bus_a.div_value = '0; bus_a.div_load = 1'b0; bus_a.run = 1'b0;
        bus_b.div_value = '0; bus_b.div_load = 1'b0; bus_b.run = 1'b0;
        #1;
        chk_a_zero("reset_a");
        chk("reset_b.edge_cnt", 32'(bus_b.edge_count), 32'd0);
        chk("reset_b.active",   32'(bus_b.active),     32'd0);
        tick(); tick();
        aresetn = 1'b1;

        // Load 2 while idle, then run
        bus_a.div_value = 32'd2; bus_a.div_load = 1'b1;
        tick();
        chk("load2.busy_set", 32'(bus_a.div_busy), 32'd1);
        chk("load2.idle",     32'(bus_a.active),   32'd0);
        bus_a.div_load = 1'b0;
        tick();
        chk("load2.busy_clr", 32'(bus_a.div_busy), 32'd0);
        chk("load2.still_idle", 32'(bus_a.active), 32'd0);
        bus_a.run = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk($sformatf("d2.out[%0d]", i), 32'(bus_a.clk_out), 32'((i % 4) < 2));
            chk($sformatf("d2.en[%0d]", i),  32'(bus_a.clk_en),  32'((i % 4) == 0));
        end
        chk("d2.edge_cnt12", bus_a.edge_count, 32'd3);

        bus_a.run = 1'b0;
        tick();
        chk("stop.active",  32'(bus_a.active),  32'd0);
        chk("stop.clk_out", 32'(bus_a.clk_out), 32'd0);
        bus_a.div_value = 32'd3; bus_a.div_load = 1'b1;
        tick();
        chk("load3.busy", 32'(bus_a.div_busy), 32'd1);

        // D=3, reload 1 mid-HIGH, then load 4 and drop run mid-HIGH
        for (int k = 0; k < 21; k++) begin
            bus_a.div_load  = seq_ld[k];
            bus_a.div_value = (k == 10) ? 32'd4 : 32'd1;
            bus_a.run       = seq_run[k];
            tick();
            chk($sformatf("seq.out[%0d]", k),  32'(bus_a.clk_out),  32'(exp_out[k]));
            chk($sformatf("seq.en[%0d]", k),   32'(bus_a.clk_en),   32'(exp_en[k]));
            chk($sformatf("seq.busy[%0d]", k), 32'(bus_a.div_busy), 32'(exp_busy[k]));
            chk($sformatf("seq.act[%0d]", k),  32'(bus_a.active),   32'(exp_act[k]));
            chk($sformatf("seq.cnt[%0d]", k),  bus_a.edge_count,    32'(exp_cnt[k]));
        end

        // D=4 running: load 5, 7 back to back, then 2 on the transfer edge
        for (int j = 0; j < 24; j++) begin
            bus_a.run       = 1'b1;
            bus_a.div_load  = (j == 1) || (j == 2) || (j == 8);
            bus_a.div_value = (j == 1) ? 32'd5 : (j == 2) ? 32'd7 : 32'd2;
            tick();
            chk($sformatf("ovr.out[%0d]", j), 32'(bus_a.clk_out),
                32'((j < 4) || (j >= 8 && j <= 14) || (j >= 22)));
            chk($sformatf("ovr.busy[%0d]", j), 32'(bus_a.div_busy), 32'((j >= 1) && (j <= 21)));
            if (j == 8) begin
                chk("ovr.en_at_xfer",  32'(bus_a.clk_en), 32'd1);
                chk("ovr.cnt_at_xfer", bus_a.edge_count,  32'd10);
            end
            if (j == 22) chk("ovr.cnt_d2", bus_a.edge_count, 32'd11);
        end
        bus_a.div_load = 1'b0;

        // Reset asserted mid-HIGH
        aresetn = 1'b0;
        #1;
        chk_a_zero("midrst");
        tick();
        aresetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("postrst.active[%0d]", i), 32'(bus_a.active),  32'd0);
            chk($sformatf("postrst.out[%0d]", i),    32'(bus_a.clk_out), 32'd0);
        end
        bus_a.div_value = 32'd2; bus_a.div_load = 1'b1;
        tick();
        chk("postrst.load_busy",   32'(bus_a.div_busy), 32'd1);
        chk("postrst.load_active", 32'(bus_a.active),   32'd0);
        bus_a.div_load = 1'b0;
        tick();
        chk("postrst.start_en",  32'(bus_a.clk_en),  32'd1);
        chk("postrst.start_out", 32'(bus_a.clk_out), 32'd1);
        chk("postrst.start_cnt", bus_a.edge_count,   32'd1);
        bus_a.run = 1'b0;

        // 4-bit instance, D=1: edge_count wraps 15 -> 0
        bus_b.div_value = 4'd1; bus_b.div_load = 1'b1;
        tick();
        bus_b.div_load = 1'b0; bus_b.run = 1'b1;
        for (int m = 0; m < 34; m++) begin
            tick();
            chk($sformatf("wrap.out[%0d]", m), 32'(bus_b.clk_out),    32'((m % 2) == 0));
            chk($sformatf("wrap.cnt[%0d]", m), 32'(bus_b.edge_count), 32'(((m / 2) + 1) % 16));
        end
        bus_b.run = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/clock_enable_gen.md
CLOCK_ENABLE_GEN -- requirements
Module: clock_enable_gen

Interface
REQ-001 The block SHALL have parameter DIV_WIDTH, default 32, giving the width of the divisor and edge counter.
REQ-002 The block SHALL have input s_axi_aclk, 1 bit: the single clock; all logic is rising-edge.
REQ-003 The block SHALL have input aresetn, 1 bit: the reset, which is asynchronous and active-low.
REQ-004 The block SHALL have input div_value, DIV_WIDTH bits: requested half-period length in s_axi_aclk cycles.
REQ-005 The block SHALL have input div_load, 1 bit: one-cycle strobe that captures div_value into the pending register.
REQ-006 The block SHALL have input run, 1 bit: level that enables generation.
REQ-007 The block SHALL have output div_busy, 1 bit: a pending divisor is not yet applied.
REQ-008 The block SHALL have output clk_out, 1 bit: registered divided square wave.
REQ-009 The block SHALL have output clk_en, 1 bit: one-cycle pulse coincident with the first cycle of each clk_out high phase.
REQ-010 The block SHALL have output active, 1 bit: high when the state is not IDLE.
REQ-011 The block SHALL have output edge_count, DIV_WIDTH bits: count of clk_en pulses since reset.

Function
REQ-012 The block SHALL implement states IDLE, HIGH and LOW, holding an internal shadow divisor D, a pending register P and a phase counter.
REQ-013 In IDLE, the block SHALL hold clk_out=0 and the counter at 0.
REQ-014 The block SHALL move from IDLE to HIGH on the next edge when run=1 and D!=0.
REQ-015 Entering HIGH, the block SHALL assert clk_out=1 and pulse clk_en=1 for exactly that one cycle.
REQ-016 In HIGH, the counter SHALL increment each cycle; when counter==D-1, the next state SHALL be LOW with counter 0 and clk_out=0.
REQ-017 In LOW, the counter SHALL increment; when counter==D-1, the next state SHALL be HIGH if run=1 and the effective D!=0, otherwise IDLE.
REQ-018 clk_out SHALL therefore be high D cycles and low D cycles, giving a period of 2*D cycles; D=1 gives a period of 2.
REQ-019 On div_load, P SHALL take div_value and div_busy SHALL be set.
REQ-020 P SHALL be transferred to D only at a period boundary (the last LOW cycle) or on any cycle in IDLE; div_busy SHALL clear on the same edge.
REQ-021 The period following a boundary SHALL use the newly applied D.
REQ-022 A div_load while busy SHALL overwrite P, and div_busy SHALL stay 1.
REQ-023 A div_load on the same cycle as a transfer SHALL cause the old P to be applied and the new value to become pending, with div_busy staying 1.
REQ-024 Applying D=0 SHALL force IDLE at the boundary; run=1 with D=0 SHALL keep the block in IDLE.
REQ-025 Deasserting run mid-period SHALL let the current period complete, then go to IDLE; no truncated high phase is permitted.
REQ-026 edge_count SHALL increment on every clk_en and wrap from all-ones to 0.
REQ-027 All outputs SHALL be registered, with no combinational path from input to output.

Reset
REQ-028 aresetn=0 SHALL immediately force IDLE, clk_out=0, clk_en=0, active=0, div_busy=0, edge_count=0, D=0, P=0 and counter=0, including mid-period.
REQ-029 After reset deasserts, the block SHALL remain in IDLE until a nonzero divisor is loaded and run=1.

Verification
REQ-030 Reset, then load 2, then run=1 -> busy clears in 1 cycle; the first clk_en comes 1 cycle after run is seen; clk_out pattern is 1,1,0,0 repeating; edge_count is 3 after 12 cycles.
REQ-031 While running D=3, load 1 at cycle 2 of HIGH -> the current period stays 6 cycles, then the period becomes 2; div_busy is high until that boundary.
REQ-032 Drop run during HIGH with D=4 -> the remaining high and the 4 low cycles complete, then active=0 and clk_out=0.
REQ-033 Load 5 then 7 on consecutive cycles while running, then load 2 on the transfer cycle -> 7 is applied and 2 remains pending with busy=1.
REQ-034 Preset edge_count near all-ones via long run with D=1 and a reduced DIV_WIDTH=4 -> edge_count wraps 15 to 0.
REQ-035 Assert aresetn=0 mid-HIGH -> all outputs are 0 in the same cycle; the block stays idle after release until load and run.
